data_muxn_reg: RTL and testbench

//  Parametrised N:1 datapath selector with a registered output and valid/ready handshake on both sides.

---
 rtl/data_muxn_reg.sv | 158 +++++++++++++++
 tb/tb_data_muxn_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_muxn_reg.sv
// data_muxn_reg: N:1 datapath selector with a registered output stage and
// valid/ready handshakes on both sides. Feeds the operand latches of the
// multicycle datapath from register-file / ALU sources.
//
// Build option: define DATA_MUXN_SKID_EN to add a one-word skid register.
// This gives a total capacity of two words and makes in_ready a flop output.
// With the macro undefined, the block is a single stage. In that build
// in_ready is combinational from out_ready.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. valid never waits for ready. Once out_valid is
// high, out_data/out_sel/out_err stay frozen until the word drains.
//
// Out-of-range selects (in_sel >= NUM_INPUTS) are still accepted. They
// produce out_data=0 with out_err=1 and take one output slot like any other
// word.

module data_muxn_reg #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready
);

  // A stored word is packed as {sel, err, data}.
  localparam int WORD_W = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0]  cap_data;
  logic              cap_err;
  logic [WORD_W-1:0] cap_word;

  logic              accept;
  logic              drain;

  logic [WORD_W-1:0] out_word_q;
  logic [WORD_W-1:0] out_word_d;
  logic              out_valid_q;
  logic              out_valid_d;

  // Select the addressed input word. An unmatched select leaves data at zero
  // and flags the error.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (in_sel == SEL_W'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  assign cap_word = {in_sel, cap_err, cap_data};
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

`ifdef DATA_MUXN_SKID_EN

  logic [WORD_W-1:0] skid_word_q;
  logic [WORD_W-1:0] skid_word_d;
  logic              skid_valid_q;
  logic              skid_valid_d;
  logic              in_ready_q;

  // in_ready comes straight from a flop, so out_ready never reaches it
  // combinationally.
  assign in_ready = in_ready_q;

  // Route each accepted word to the output stage or to the skid register.
  // The skid always holds the younger word, and it refills the output stage
  // first on the next drain.
  always_comb begin
    out_word_d   = out_word_q;
    out_valid_d  = out_valid_q;
    skid_word_d  = skid_word_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_word_d   = skid_word_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_word_d = cap_word;
        end
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_word_d  = cap_word;
        out_valid_d = 1'b1;
      end else begin
        skid_word_d  = cap_word;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Skid storage and registered ready. Ready stays low during reset and
  // rises on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_word_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_word_q  <= skid_word_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

`else

  // Single stage: accept whenever the output register is empty or is being
  // emptied this cycle.
  assign in_ready = !reset & (!out_valid_q | out_ready);

  // Load on accept. Otherwise go empty on drain. Otherwise hold.
  always_comb begin
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_word_d  = cap_word;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

`endif

  // Output stage register. Reset clears both the word and the valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign {out_sel, out_err, out_data} = out_word_q;
  assign out_valid                    = out_valid_q;

endmodule

// File: tb/tb_data_muxn_reg.sv
// Testbench for data_muxn_reg. Two instances share the stimulus:
//   dut_a has 4 inputs.
//   dut_b has 3 inputs, so select 3 is out of range for it.
// A queue model, fed from the hand-computed vector table, gives the
// expected output word and ready level after every edge.
// The same file covers both builds (DATA_MUXN_SKID_EN defined or not).

module tb_data_muxn_reg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 2;
  localparam int W     = WIDTH + SEL_W + 1;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [63:0]       in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_valid;
  logic              out_ready;

  logic              in_ready_a, out_err_a, out_valid_a;
  logic [WIDTH-1:0]  out_data_a;
  logic [SEL_W-1:0]  out_sel_a;
  logic              in_ready_b, out_err_b, out_valid_b;
  logic [WIDTH-1:0]  out_data_b;
  logic [SEL_W-1:0]  out_sel_b;

  data_muxn_reg #(.WIDTH(WIDTH), .NUM_INPUTS(4), .SEL_W(SEL_W)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_err(out_err_a), .out_valid(out_valid_a),
    .out_ready(out_ready)
  );

  data_muxn_reg #(.WIDTH(WIDTH), .NUM_INPUTS(3), .SEL_W(SEL_W)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data[47:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_err(out_err_b), .out_valid(out_valid_b),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [63:0]      data;
    logic [SEL_W-1:0] sel;
    logic [15:0]      exp_a;
    logic             err_a;
    logic [15:0]      exp_b;
    logic             err_b;
  } vec_t;

  vec_t tab[12];
  int   cur;

  // Scoreboard
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  bit           armed;
  int           n_cmp;
  int           n_err;

  function automatic logic model_ready();
`ifdef DATA_MUXN_SKID_EN
    return armed && (exp_a_q.size() < 2);
`else
    return !reset && (exp_a_q.size() == 0 || out_ready);
`endif
  endfunction

  // Transfers at each edge, using the values the DUT sampled.
  always @(posedge clk) begin : model
    logic acc, drn;
    if (reset) begin
      exp_a_q.delete();
      exp_b_q.delete();
      armed = 1'b0;
    end else begin
      acc = in_valid && model_ready();
      drn = (exp_a_q.size() > 0) && out_ready;
      if (drn) begin
        void'(exp_a_q.pop_front());
        void'(exp_b_q.pop_front());
      end
      if (acc) begin
        exp_a_q.push_back({tab[cur].sel, tab[cur].err_a, tab[cur].exp_a});
        exp_b_q.push_back({tab[cur].sel, tab[cur].err_b, tab[cur].exp_b});
      end
      armed = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready_a", {31'd0, in_ready_a}, {31'd0, model_ready()});
    chk("in_ready_b", {31'd0, in_ready_b}, {31'd0, model_ready()});
    chk("out_valid_a", {31'd0, out_valid_a}, {31'd0, exp_a_q.size() > 0});
    chk("out_valid_b", {31'd0, out_valid_b}, {31'd0, exp_b_q.size() > 0});
    if (exp_a_q.size() > 0)
      chk("out_word_a", 32'({out_sel_a, out_err_a, out_data_a}), 32'(exp_a_q[0]));
    if (exp_b_q.size() > 0)
      chk("out_word_b", 32'({out_sel_b, out_err_b, out_data_b}), 32'(exp_b_q[0]));
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input int i);
    cur     = i;
    in_data = tab[i].data;
    in_sel  = tab[i].sel;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    cur       = 0;
    armed     = 1'b0;
    n_cmp     = 0;
    n_err     = 0;

    //        data                    sel   exp_a    err  exp_b    err
    tab[0]  = '{64'h4444_3333_2222_1111, 2'd2, 16'h3333, 1'b0, 16'h3333, 1'b0};
    tab[1]  = '{64'h4444_3333_2222_1111, 2'd3, 16'h4444, 1'b0, 16'h0000, 1'b1};
    tab[2]  = '{64'h4444_3333_2222_1111, 2'd0, 16'h1111, 1'b0, 16'h1111, 1'b0};
    tab[3]  = '{64'h4444_3333_2222_1111, 2'd1, 16'h2222, 1'b0, 16'h2222, 1'b0};
    tab[4]  = '{64'hDEAD_BEEF_CAFE_F00D, 2'd0, 16'hF00D, 1'b0, 16'hF00D, 1'b0};
    tab[5]  = '{64'hDEAD_BEEF_CAFE_F00D, 2'd1, 16'hCAFE, 1'b0, 16'hCAFE, 1'b0};
    tab[6]  = '{64'hDEAD_BEEF_CAFE_F00D, 2'd2, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
    tab[7]  = '{64'hDEAD_BEEF_CAFE_F00D, 2'd3, 16'hDEAD, 1'b0, 16'h0000, 1'b1};
    tab[8]  = '{64'hFFFF_0000_FFFF_0000, 2'd1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
    tab[9]  = '{64'h0001_8000_7FFF_ABCD, 2'd3, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tab[10] = '{64'h0001_8000_7FFF_ABCD, 2'd2, 16'h8000, 1'b0, 16'h8000, 1'b0};
    tab[11] = '{64'h0001_8000_7FFF_ABCD, 2'd0, 16'hABCD, 1'b0, 16'hABCD, 1'b0};

    // Reset held for 3 cycles, then released
    repeat (3) begin
      tick();
      chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      chk("rst_out_data", 32'(out_data_a), 32'd0);
    end
    reset = 1'b0;
    tick();
    chk("ready_after_release_a", {31'd0, in_ready_a}, 32'd1);
    chk("ready_after_release_b", {31'd0, in_ready_b}, 32'd1);

    // Table vectors, one per cycle; each appears on the outputs after one edge
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(i);
      in_valid = 1'b1;
      tick();
      chk("vec_valid_a", {31'd0, out_valid_a}, 32'd1);
      chk("vec_data_a", 32'(out_data_a), 32'(tab[i].exp_a));
      chk("vec_sel_a", 32'(out_sel_a), 32'(tab[i].sel));
      chk("vec_err_a", {31'd0, out_err_a}, {31'd0, tab[i].err_a});
      chk("vec_data_b", 32'(out_data_b), 32'(tab[i].exp_b));
      chk("vec_err_b", {31'd0, out_err_b}, {31'd0, tab[i].err_b});
    end
    in_valid = 1'b0;
    tick();
    chk("valid_one_cycle", {31'd0, out_valid_a}, 32'd0);

    // 20-word stream, selects cycling 0,1,2,3
    for (int i = 0; i < 20; i++) begin
      drive(4 + (i % 4));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Backpressure for 5 cycles with the source always valid
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8 + (i % 4));
      in_valid = 1'b1;
      tick();
    end
    chk("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", {31'd0, out_valid_a}, 32'd0);

    // Reset while words are held; no stale word afterwards
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i);
      in_valid = 1'b1;
      tick();
    end
    reset = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    armed = 1'b0;
    #1;
    chk("rst_mid_valid_a", {31'd0, out_valid_a}, 32'd0);
    chk("rst_mid_valid_b", {31'd0, out_valid_b}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready_a}, 32'd0);
    in_valid = 1'b0;
    repeat (2) tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("no_stale_word", {31'd0, out_valid_a}, 32'd0);

    // Mixed traffic with random valid and ready
    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 11));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("final_empty", {31'd0, out_valid_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
